led_blink_arbiter: RTL and testbench

//  Shares one board LED between N_REQ requesters. Each requester asks for a

---
 rtl/led_blink_arbiter_if.sv | 23 ++
 rtl/led_blink_arbiter.sv | 135 +++++++++++++
 tb/tb_led_blink_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/led_blink_arbiter_if.sv
// LED arbiter bus: requester side (req/half_period/blink_count) and
// LED side (led/grant/done/busy). master = requesters, slave = arbiter.
interface led_blink_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req;
    logic [16*N_REQ-1:0] half_period;
    logic [8*N_REQ-1:0]  blink_count;
    logic                led;
    logic [N_REQ-1:0]    grant;
    logic [N_REQ-1:0]    done;
    logic                busy;

    modport master (
        output req, half_period, blink_count,
        input  led, grant, done, busy
    );

    modport slave (
        input  req, half_period, blink_count,
        output led, grant, done, busy
    );
endinterface

// File: rtl/led_blink_arbiter.sv
// Round-robin sharing of one LED among N_REQ blink-burst requesters.
// Ports: clk, rst (async high), bus (slave: req/half_period/blink_count in; led/grant/done/busy out).
module led_blink_arbiter #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000,
    parameter int N_REQ   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    led_blink_arbiter_if.slave   bus
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW = $clog2(TICK_DIV);
    localparam int RW = $clog2(N_REQ);

    typedef enum logic {IDLE, BLINK} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   pre, pre_n;
    logic [15:0]     ms, ms_n;
    logic [15:0]     hp, hp_n;
    logic [8:0]      tl, tl_n;
    logic            led, led_n;
    logic [N_REQ-1:0] grant, grant_n;
    logic [N_REQ-1:0] done, done_n;
    logic [RW-1:0]   rr, rr_n;

    logic [RW-1:0]   win;
    logic            found;
    int              idx;
    logic [15:0]     hp_in;
    logic [7:0]      bc_in;
    logic            tick, expire, complete;

    // Scan starts just past the last owner, so it becomes lowest priority.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = int'(rr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = RW'(idx);
            end
        end
    end

    assign hp_in = bus.half_period[16*win +: 16];
    assign bc_in = bus.blink_count[8*win +: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pre   <= '0;
            ms    <= '0;
            hp    <= 16'd1;
            tl    <= '0;
            led   <= 1'b0;
            grant <= '0;
            done  <= '0;
            rr    <= RW'(N_REQ - 1);
        end else begin
            state <= state_n;
            pre   <= pre_n;
            ms    <= ms_n;
            hp    <= hp_n;
            tl    <= tl_n;
            led   <= led_n;
            grant <= grant_n;
            done  <= done_n;
            rr    <= rr_n;
        end
    end

    always_comb begin
        state_n  = state;
        pre_n    = pre;
        ms_n     = ms;
        hp_n     = hp;
        tl_n     = tl;
        led_n    = led;
        grant_n  = grant;
        done_n   = '0;
        rr_n     = rr;
        tick     = 1'b0;
        expire   = 1'b0;
        complete = 1'b0;
        unique case (state)
            IDLE: begin
                pre_n = '0;
                if (found) begin
                    state_n = BLINK;
                    grant_n = '0;
                    grant_n[win] = 1'b1;
                    rr_n    = win;
                    hp_n    = (hp_in == 16'd0) ? 16'd1 : hp_in;
                    tl_n    = {bc_in, 1'b0};
                    ms_n    = '0;
                    led_n   = (bc_in != 8'd0);
                end
            end
            BLINK: begin
                tick   = (pre == PW'(TICK_DIV - 1));
                pre_n  = tick ? '0 : pre + 1'b1;
                expire = tick && (ms == hp - 16'd1);
                // rr holds the current owner while in BLINK.
                if (tl == 9'd0) begin
                    complete = 1'b1;
                end else if (expire) begin
                    ms_n  = '0;
                    led_n = ~led;
                    tl_n  = tl - 9'd1;
                    if (tl == 9'd1) complete = 1'b1;
                end else if (tick) begin
                    ms_n = ms + 16'd1;
                end
                if (complete || !bus.req[rr]) begin
                    state_n = IDLE;
                    pre_n   = '0;
                    led_n   = 1'b0;
                    grant_n = '0;
                    if (complete) done_n[rr] = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.led   = led;
    assign bus.grant = grant;
    assign bus.done  = done;
    assign bus.busy  = (state == BLINK);
endmodule

// File: tb/tb_led_blink_arbiter.sv
// Directed bench for led_blink_arbiter, TICK_DIV=10, N_REQ=4.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_led_blink_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    led_blink_arbiter_if #(.N_REQ(4)) bus ();

    led_blink_arbiter #(
        .CLK_HZ (1000),
        .TICK_HZ(100),
        .N_REQ  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setreq(input int i, input logic [15:0] h,
                          input logic [7:0] c);
        bus.half_period[16*i +: 16] = h;
        bus.blink_count[8*i +: 8]   = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        cyc(1);
        rst = 1'b0;
    endtask

    initial begin
        bus.req = '0;
        bus.half_period = '0;
        bus.blink_count = '0;
        cyc(2);
        check("rst_led", 32'(bus.led), 0);
        check("rst_grant", 32'(bus.grant), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_busy", 32'(bus.busy), 0);
        rst = 1'b0;
        cyc(1);

        // 1: hp=2 count=1
        setreq(0, 16'd2, 8'd1);
        bus.req = 4'b0001;
        cyc(1);
        check("t1_grant", 32'(bus.grant), 32'h1);
        check("t1_led_on", 32'(bus.led), 1);
        check("t1_busy", 32'(bus.busy), 1);
        cyc(19);
        check("t1_led_19", 32'(bus.led), 1);
        cyc(1);
        check("t1_led_20", 32'(bus.led), 0);
        cyc(19);
        check("t1_done_39", 32'(bus.done), 0);
        check("t1_grant_39", 32'(bus.grant), 32'h1);
        cyc(1);
        check("t1_done_40", 32'(bus.done), 32'h1);
        check("t1_grant_40", 32'(bus.grant), 0);
        check("t1_busy_40", 32'(bus.busy), 0);
        bus.req = '0;
        cyc(1);
        check("t1_done_pulse", 32'(bus.done), 0);

        // 2: round robin between req0 and req2
        rst = 1'b1;
        setreq(0, 16'd1, 8'd1);
        setreq(2, 16'd1, 8'd1);
        bus.req = 4'b0101;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        check("t2_g0", 32'(bus.grant), 32'h1);
        cyc(20);
        check("t2_done0", 32'(bus.done), 32'h1);
        check("t2_idle0", 32'(bus.grant), 0);
        cyc(1);
        check("t2_g2", 32'(bus.grant), 32'h4);
        cyc(20);
        check("t2_done2", 32'(bus.done), 32'h4);
        check("t2_idle2", 32'(bus.grant), 0);
        cyc(1);
        check("t2_g0b", 32'(bus.grant), 32'h1);
        do_reset();

        // 3: count=0, req dropped at the completing edge
        setreq(1, 16'd3, 8'd0);
        bus.req = 4'b0010;
        cyc(1);
        check("t3_grant", 32'(bus.grant), 32'h2);
        check("t3_led", 32'(bus.led), 0);
        bus.req = '0;
        cyc(1);
        check("t3_done", 32'(bus.done), 32'h2);
        check("t3_grant0", 32'(bus.grant), 0);
        check("t3_led0", 32'(bus.led), 0);
        do_reset();

        // 4: abort req3 at cycle 30
        setreq(3, 16'd5, 8'd3);
        bus.req = 4'b1000;
        cyc(1);
        check("t4_grant", 32'(bus.grant), 32'h8);
        cyc(29);
        check("t4_led29", 32'(bus.led), 1);
        bus.req = '0;
        cyc(1);
        check("t4_led", 32'(bus.led), 0);
        check("t4_grant0", 32'(bus.grant), 0);
        check("t4_done", 32'(bus.done), 0);
        check("t4_busy", 32'(bus.busy), 0);
        cyc(1);
        check("t4_done2", 32'(bus.done), 0);
        do_reset();

        // 5: async reset mid-burst
        setreq(0, 16'd1, 8'd5);
        setreq(1, 16'd1, 8'd5);
        bus.req = 4'b0001;
        cyc(1);
        check("t5_grant", 32'(bus.grant), 32'h1);
        cyc(5);
        #2 rst = 1'b1;
        #1;
        check("t5_led", 32'(bus.led), 0);
        check("t5_grant0", 32'(bus.grant), 0);
        check("t5_busy", 32'(bus.busy), 0);
        check("t5_done", 32'(bus.done), 0);
        bus.req = 4'b0011;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        check("t5_regrant", 32'(bus.grant), 32'h1);
        do_reset();

        // 6: hp=0 acts as hp=1; later input changes ignored
        setreq(0, 16'd0, 8'd2);
        bus.req = 4'b0001;
        cyc(1);
        check("t6_led_a", 32'(bus.led), 1);
        setreq(0, 16'd7, 8'd9);
        cyc(9);
        check("t6_led_9", 32'(bus.led), 1);
        cyc(1);
        check("t6_led_b", 32'(bus.led), 0);
        cyc(10);
        check("t6_led_c", 32'(bus.led), 1);
        cyc(10);
        check("t6_led_d", 32'(bus.led), 0);
        check("t6_done_30", 32'(bus.done), 0);
        cyc(10);
        check("t6_done", 32'(bus.done), 32'h1);
        check("t6_led_e", 32'(bus.led), 0);
        bus.req = '0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
